// File: rtl/ysyx_25030085_gpr_wb_pkg.sv
// Shared types and constants for the NPC register file / write-back slice.
package ysyx_25030085_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  typedef enum logic {
    WB_IDLE     = 1'b0,
    WB_WAIT_MEM = 1'b1
  } wb_state_e;

  typedef enum logic {
    DUMP_IDLE = 1'b0,
    DUMP_RUN  = 1'b1
  } dump_state_e;

  // RV32E builds leave the upper half of the index space unimplemented.
  function automatic logic idx_legal(input logic [REG_ADDR_W-1:0] idx, input int nr_regs);
    return (32'(idx) < 32'(nr_regs));
  endfunction

endpackage

// File: rtl/ysyx_25030085_gpr_wb_if.sv
// Write-back request bus from the execute/memory stages into the register file.
interface ysyx_25030085_gpr_wb_if
  import ysyx_25030085_pkg::*;
#(
  parameter int XLEN = 32
) ();

  logic                  wb_valid;
  logic                  wb_ready;
  logic [REG_ADDR_W-1:0] wb_rd;
  wb_sel_e               wb_sel;
  logic [XLEN-1:0]       alu_result;
  logic [XLEN-1:0]       pc;
  logic [XLEN-1:0]       imm;
  logic                  mem_rvalid;
  logic [XLEN-1:0]       mem_rdata;

  modport master (
    output wb_valid, wb_rd, wb_sel, alu_result, pc, imm, mem_rvalid, mem_rdata,
    input  wb_ready
  );

  modport slave (
    input  wb_valid, wb_rd, wb_sel, alu_result, pc, imm, mem_rvalid, mem_rdata,
    output wb_ready
  );

endinterface

// File: rtl/ysyx_25030085_gpr_wb_dump.sv
// Register dump sequencer: streams every architectural register, one per cycle.
module ysyx_25030085_gpr_dump
  import ysyx_25030085_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NR_REGS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_dump_req,
  output logic [REG_ADDR_W-1:0] o_rd_idx,
  input  logic [XLEN-1:0]       i_rd_data,
  output logic                  o_dump_valid,
  output logic [REG_ADDR_W-1:0] o_dump_idx,
  output logic [XLEN-1:0]       o_dump_data,
  output logic                  o_dump_done
);

  localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NR_REGS - 1);

  dump_state_e           r_state;
  logic [REG_ADDR_W-1:0] r_cnt;
  logic                  r_valid;
  logic [REG_ADDR_W-1:0] r_idx;
  logic [XLEN-1:0]       r_data;
  logic                  r_done;

  assign o_rd_idx     = r_cnt;
  assign o_dump_valid = r_valid;
  assign o_dump_idx   = r_idx;
  assign o_dump_data  = r_data;
  assign o_dump_done  = r_done;

  // Dump FSM; the array is sampled at the edge, so same-cycle writes are not yet visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DUMP_IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        DUMP_IDLE: begin
          r_valid <= 1'b0;
          r_done  <= 1'b0;
          r_idx   <= '0;
          r_data  <= '0;
          if (i_dump_req) begin
            r_state <= DUMP_RUN;
            r_cnt   <= '0;
          end
        end
        DUMP_RUN: begin
          r_valid <= 1'b1;
          r_idx   <= r_cnt;
          r_data  <= i_rd_data;
          r_done  <= (r_cnt == LAST_IDX);
          r_cnt   <= r_cnt + 5'd1;
          if (r_cnt == LAST_IDX) begin
            r_state <= DUMP_IDLE;
          end
        end
        default: begin
          r_state <= DUMP_IDLE;
          r_valid <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ysyx_25030085_gpr_wb.sv
// GPR array with write-back source select, load-stall handshake and dump port.
// Optional same-cycle write bypass on the read ports: YSYX_25030085_GPR_BYPASS_EN.
module ysyx_25030085_gpr_wb
  import ysyx_25030085_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NR_REGS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  output logic [XLEN-1:0]       o_rs1_data,
  output logic [XLEN-1:0]       o_rs2_data,
  ysyx_25030085_gpr_wb_if.slave wb,
  input  logic                  i_dump_req,
  output logic                  o_dump_valid,
  output logic [REG_ADDR_W-1:0] o_dump_idx,
  output logic [XLEN-1:0]       o_dump_data,
  output logic                  o_dump_done
);

  localparam int IDX_W = $clog2(NR_REGS);

  logic [XLEN-1:0]       r_regs [NR_REGS];
  wb_state_e             r_wb_state;
  logic [REG_ADDR_W-1:0] r_pend_rd;
  logic                  r_wb_ready;

  logic                  w_commit_en;
  logic [REG_ADDR_W-1:0] w_commit_rd;
  logic [XLEN-1:0]       w_commit_data;
  logic                  w_load_wait;
  logic                  w_wr_en;
  logic                  w_byp_en;
  logic [REG_ADDR_W-1:0] w_dump_rd_idx;
  logic [XLEN-1:0]       w_dump_rd_data;

  function automatic logic [XLEN-1:0] read_mux(
    input logic [REG_ADDR_W-1:0] addr,
    input logic [XLEN-1:0]       stored,
    input logic                  byp_en,
    input logic [REG_ADDR_W-1:0] byp_rd,
    input logic [XLEN-1:0]       byp_data
  );
    logic [XLEN-1:0] v;
    if ((addr == 5'd0) || !idx_legal(addr, NR_REGS)) begin
      v = '0;
    end else if (byp_en && (byp_rd == addr)) begin
      v = byp_data;
    end else begin
      v = stored;
    end
    return v;
  endfunction

  // Select what (if anything) commits to the array at the next edge.
  always_comb begin
    w_commit_en   = 1'b0;
    w_commit_rd   = wb.wb_rd;
    w_commit_data = wb.alu_result;
    w_load_wait   = 1'b0;
    if (r_wb_state == WB_WAIT_MEM) begin
      w_commit_en   = wb.mem_rvalid;
      w_commit_rd   = r_pend_rd;
      w_commit_data = wb.mem_rdata;
    end else if (wb.wb_valid) begin
      case (wb.wb_sel)
        WB_ALU: begin
          w_commit_en   = 1'b1;
          w_commit_data = wb.alu_result;
        end
        WB_MEM: begin
          w_commit_en   = wb.mem_rvalid;
          w_commit_data = wb.mem_rdata;
          w_load_wait   = !wb.mem_rvalid;
        end
        WB_PC4: begin
          w_commit_en   = 1'b1;
          w_commit_data = wb.pc + {{(XLEN-3){1'b0}}, 3'd4};
        end
        WB_IMM: begin
          w_commit_en   = 1'b1;
          w_commit_data = wb.imm;
        end
        default: begin
          w_commit_en = 1'b0;
        end
      endcase
    end else begin
      w_commit_en = 1'b0;
    end
  end

  assign w_wr_en = w_commit_en && (w_commit_rd != 5'd0) && idx_legal(w_commit_rd, NR_REGS);

`ifdef YSYX_25030085_GPR_BYPASS_EN
  assign w_byp_en = w_wr_en;
`else
  assign w_byp_en = 1'b0;
`endif

  // Register array storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[w_commit_rd[IDX_W-1:0]] <= w_commit_data;
    end
  end

  // Write-back FSM; ready is registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_state <= WB_IDLE;
      r_pend_rd  <= '0;
      r_wb_ready <= 1'b1;
    end else begin
      case (r_wb_state)
        WB_IDLE: begin
          if (w_load_wait) begin
            r_wb_state <= WB_WAIT_MEM;
            r_pend_rd  <= wb.wb_rd;
            r_wb_ready <= 1'b0;
          end
        end
        WB_WAIT_MEM: begin
          if (wb.mem_rvalid) begin
            r_wb_state <= WB_IDLE;
            r_wb_ready <= 1'b1;
          end
        end
        default: begin
          r_wb_state <= WB_IDLE;
          r_wb_ready <= 1'b1;
        end
      endcase
    end
  end

  assign wb.wb_ready = r_wb_ready;

  assign o_rs1_data = read_mux(i_rs1_addr, r_regs[i_rs1_addr[IDX_W-1:0]],
                               w_byp_en, w_commit_rd, w_commit_data);
  assign o_rs2_data = read_mux(i_rs2_addr, r_regs[i_rs2_addr[IDX_W-1:0]],
                               w_byp_en, w_commit_rd, w_commit_data);

  assign w_dump_rd_data = idx_legal(w_dump_rd_idx, NR_REGS) ?
                          r_regs[w_dump_rd_idx[IDX_W-1:0]] : '0;

  ysyx_25030085_gpr_dump #(
    .XLEN    (XLEN),
    .NR_REGS (NR_REGS)
  ) u_dump (
    .clk          (clk),
    .rst          (rst),
    .i_dump_req   (i_dump_req),
    .o_rd_idx     (w_dump_rd_idx),
    .i_rd_data    (w_dump_rd_data),
    .o_dump_valid (o_dump_valid),
    .o_dump_idx   (o_dump_idx),
    .o_dump_data  (o_dump_data),
    .o_dump_done  (o_dump_done)
  );

endmodule
